// File: rtl/tm_quanta_master_pkg.sv
// +----------------------------------------------------------------------+
// | tm_quanta_master_pkg: shared types for the TM quanta barrier master. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package tm_quanta_master_pkg;

  localparam int IO_AWIDTH = 32;
  localparam int IO_DWIDTH = 32;

  typedef struct packed {
    logic clk;
  } iu_clk_type;

  typedef struct packed {
    logic tm_dbg_start;
    logic tm_dbg_stop;
  } dma_tm_ctrl_type;

  typedef struct packed {
    logic                 en;
    logic                 rw;
    logic [IO_AWIDTH-1:0] addr;
    logic [IO_DWIDTH-1:0] wdata;
  } io_bus_in_type;

  typedef enum logic [1:0] {
    tm_NOP   = 2'd0,
    tm_START = 2'd1
  } tm_unit_ctrl_type;

  typedef logic [1:0] tm_qmaster_state_type;

  localparam tm_qmaster_state_type QM_SIM   = 2'd0;
  localparam tm_qmaster_state_type QM_ISSUE = 2'd1;
  localparam tm_qmaster_state_type QM_HALT  = 2'd2;

  // Config space is word addressed on a byte bus.
  function automatic logic [1:0] cfg_word(input logic [IO_AWIDTH-1:0] addr);
    return addr[3:2];
  endfunction

endpackage

`default_nettype wire

// File: rtl/tm_quanta_master.sv
// +----------------------------------------------------------------------+
// | tm_quanta_master: global quanta barrier; issues tm_START to all TM   |
// | units and advances target time once every unit reports done.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tm_quanta_master
  import tm_quanta_master_pkg::*;
#(
  parameter int         NUNIT    = 2,
  parameter logic [3:0] ADDRMASK = 4'h1,
  parameter int         QCNTMSB  = 31,
  parameter int         HCNTMSB  = 31
) (
  input  iu_clk_type                   gclk,
  input  logic                         rst,
  input  dma_tm_ctrl_type              dma2tm,
  input  io_bus_in_type                io_in,
  input  logic [NUNIT-1:0]             unit_done,
  output tm_unit_ctrl_type [NUNIT-1:0] unit_ctrl,
  output logic [QCNTMSB:0]             quanta_count,
  output logic [HCNTMSB:0]             last_host_cyc,
  output logic                         quanta_tick,
  output logic                         running,
  output logic                         proto_err
);

  tm_qmaster_state_type         r_state;
  tm_unit_ctrl_type [NUNIT-1:0] r_unit_ctrl;
  logic [QCNTMSB:0]             r_qcount;
  logic [QCNTMSB:0]             r_qlimit;
  logic [HCNTMSB:0]             r_hcnt;
  logic [HCNTMSB:0]             r_last_host;
  logic [NUNIT-1:0]             r_done_mask;
  logic                         r_run_en;
  logic                         r_tick;
  logic                         r_running;
  logic                         r_proto_err;

  tm_qmaster_state_type w_state_nxt;
  logic                 w_cfg_hit;
  logic [QCNTMSB:0]     w_qlimit_nxt;
  logic                 w_clr;
  logic                 w_run_en_nxt;
  logic                 w_in_sim;
  logic                 w_all_done;
  logic                 w_dup;
  logic [QCNTMSB:0]     w_qcount_inc;
  logic [HCNTMSB:0]     w_hcnt_inc;
  logic                 w_unused;

  assign w_unused = ^io_in;

  always_comb begin
    w_cfg_hit    = io_in.en & io_in.rw & (io_in.addr[IO_AWIDTH-1 -: 4] == ADDRMASK);
    w_qlimit_nxt = (w_cfg_hit && cfg_word(io_in.addr) == 2'd0) ? io_in.wdata[QCNTMSB:0] : r_qlimit;
    w_clr        = w_cfg_hit && (cfg_word(io_in.addr) == 2'd1) && io_in.wdata[0];
    // Start/stop take effect before the barrier decision of the same cycle.
    w_run_en_nxt = dma2tm.tm_dbg_start ? 1'b1 : (dma2tm.tm_dbg_stop ? 1'b0 : r_run_en);
    w_in_sim     = (r_state == QM_SIM);
    w_all_done   = w_in_sim & (&(r_done_mask | unit_done));
    w_dup        = w_in_sim ? |(r_done_mask & unit_done) : |unit_done;
    w_qcount_inc = r_qcount + 1'b1;
    w_hcnt_inc   = (&r_hcnt) ? r_hcnt : r_hcnt + 1'b1;

    w_state_nxt = r_state;
    case (r_state)
      QM_SIM: begin
        if (w_all_done) begin
          if (w_run_en_nxt && (w_qlimit_nxt == '0 || w_qcount_inc != w_qlimit_nxt))
            w_state_nxt = QM_ISSUE;
          else
            w_state_nxt = QM_HALT;
        end
      end
      QM_ISSUE: w_state_nxt = QM_SIM;
      QM_HALT: begin
        if (w_run_en_nxt && (w_qlimit_nxt == '0 || r_qcount != w_qlimit_nxt))
          w_state_nxt = QM_ISSUE;
      end
      default: w_state_nxt = QM_SIM;
    endcase
  end

  always_ff @(posedge gclk.clk) begin
    if (rst) begin
      // Units come out of reset holding the quantum-0 token, so start in SIM.
      r_state     <= QM_SIM;
      r_qcount    <= '0;
      r_qlimit    <= '0;
      r_hcnt      <= '0;
      r_last_host <= '0;
      r_done_mask <= '0;
      r_run_en    <= 1'b0;
      r_tick      <= 1'b0;
      r_running   <= 1'b0;
      r_proto_err <= 1'b0;
      for (int i = 0; i < NUNIT; i++) r_unit_ctrl[i] <= tm_NOP;
    end else begin
      r_state   <= w_state_nxt;
      r_run_en  <= w_run_en_nxt;
      r_qlimit  <= w_qlimit_nxt;
      r_tick    <= w_all_done;
      r_running <= (w_state_nxt == QM_SIM);
      for (int i = 0; i < NUNIT; i++)
        r_unit_ctrl[i] <= (w_state_nxt == QM_ISSUE) ? tm_START : tm_NOP;

      if (w_clr) r_proto_err <= 1'b0;
      if (w_dup) r_proto_err <= 1'b1;

      if (w_clr) r_last_host <= '0;
      if (w_all_done) begin
        r_last_host <= w_hcnt_inc;
        r_qcount    <= w_qcount_inc;
        r_done_mask <= '0;
        r_hcnt      <= '0;
      end else if (w_in_sim) begin
        r_done_mask <= r_done_mask | unit_done;
        r_hcnt      <= w_hcnt_inc;
      end
    end
  end

  assign unit_ctrl     = r_unit_ctrl;
  assign quanta_count  = r_qcount;
  assign last_host_cyc = r_last_host;
  assign quanta_tick   = r_tick;
  assign running       = r_running;
  assign proto_err     = r_proto_err;

endmodule

`default_nettype wire

// File: tb/tb_tm_quanta_master.sv
// +----------------------------------------------------------------------+
// | tb_tm_quanta_master: directed self-checking bench for the barrier.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_tm_quanta_master;
  import tm_quanta_master_pkg::*;

  localparam int NUNIT = 2;
  localparam logic [3:0] BOTH_START = 4'b0101;

  iu_clk_type                   gclk;
  logic                         rst;
  dma_tm_ctrl_type              dma2tm;
  io_bus_in_type                io_in;
  logic [NUNIT-1:0]             unit_done;
  tm_unit_ctrl_type [NUNIT-1:0] unit_ctrl;
  logic [31:0]                  quanta_count;
  logic [31:0]                  last_host_cyc;
  logic                         quanta_tick;
  logic                         running;
  logic                         proto_err;
  logic [3:0]                   w_uc;

  int n_checks = 0;
  int n_fail   = 0;

  assign w_uc = unit_ctrl;

  tm_quanta_master #(
    .NUNIT   (NUNIT),
    .ADDRMASK(4'h1),
    .QCNTMSB (31),
    .HCNTMSB (31)
  ) dut (
    .gclk         (gclk),
    .rst          (rst),
    .dma2tm       (dma2tm),
    .io_in        (io_in),
    .unit_done    (unit_done),
    .unit_ctrl    (unit_ctrl),
    .quanta_count (quanta_count),
    .last_host_cyc(last_host_cyc),
    .quanta_tick  (quanta_tick),
    .running      (running),
    .proto_err    (proto_err)
  );

  initial gclk.clk = 1'b0;
  always #5 gclk.clk = ~gclk.clk;

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge gclk.clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] word, input logic [31:0] data);
    io_in.en    = 1'b1;
    io_in.rw    = 1'b1;
    io_in.addr  = 32'h1000_0000 | {28'd0, word, 2'b00};
    io_in.wdata = data;
  endtask

  task automatic cfg_idle();
    io_in = '0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_uc"},    64'(w_uc), 64'h0);
    chk({tag, "_qcnt"},  64'(quanta_count), 64'd0);
    chk({tag, "_last"},  64'(last_host_cyc), 64'd0);
    chk({tag, "_tick"},  64'(quanta_tick), 64'd0);
    chk({tag, "_run"},   64'(running), 64'd0);
    chk({tag, "_perr"},  64'(proto_err), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    dma2tm = '0;
    io_in = '0;
    unit_done = '0;
    cyc(2);
    chk_reset("reset");

    // Test 1: done[0]@5, done[1]@9 -> tick and START @10, last_host_cyc=10
    rst = 1'b0;
    dma2tm.tm_dbg_start = 1'b1;
    cyc(1);
    dma2tm.tm_dbg_start = 1'b0;
    chk("t1_running", 64'(running), 64'd1);
    cyc(4);
    unit_done = 2'b01;
    cyc(1);
    unit_done = 2'b00;
    chk("t1_tick_early", 64'(quanta_tick), 64'd0);
    cyc(3);
    unit_done = 2'b10;
    cyc(1);
    unit_done = 2'b00;
    chk("t1_tick", 64'(quanta_tick), 64'd1);
    chk("t1_start", 64'(w_uc), 64'(BOTH_START));
    chk("t1_qcnt", 64'(quanta_count), 64'd1);
    chk("t1_last", 64'(last_host_cyc), 64'd10);
    cyc(1);
    chk("t1_tick_off", 64'(quanta_tick), 64'd0);
    chk("t1_start_off", 64'(w_uc), 64'h0);
    chk("t1_running2", 64'(running), 64'd1);

    // Test 2: both done same cycle -> one tick, one START, mask cleared
    unit_done = 2'b11;
    cyc(1);
    unit_done = 2'b00;
    chk("t2_tick", 64'(quanta_tick), 64'd1);
    chk("t2_start", 64'(w_uc), 64'(BOTH_START));
    chk("t2_qcnt", 64'(quanta_count), 64'd2);
    chk("t2_last", 64'(last_host_cyc), 64'd1);
    cyc(1);
    chk("t2_single_start", 64'(w_uc), 64'h0);
    chk("t2_single_tick", 64'(quanta_tick), 64'd0);
    unit_done = 2'b10;
    cyc(1);
    unit_done = 2'b00;
    chk("t2_mask_clear", 64'(quanta_tick), 64'd0);
    unit_done = 2'b01;
    cyc(1);
    unit_done = 2'b00;
    chk("t2_close2", 64'(quanta_tick), 64'd1);
    chk("t2_qcnt2", 64'(quanta_count), 64'd3);
    chk("t2_last2", 64'(last_host_cyc), 64'd2);
    chk("t2_perr", 64'(proto_err), 64'd0);

    // Test 3: qlimit=3 -> two STARTs then HALT; qlimit=5 -> two more quanta
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cfg_write(2'd0, 32'd3);
    dma2tm.tm_dbg_start = 1'b1;
    cyc(1);
    cfg_idle();
    dma2tm.tm_dbg_start = 1'b0;
    for (int q = 0; q < 3; q++) begin
      unit_done = 2'b11;
      cyc(1);
      unit_done = 2'b00;
      chk($sformatf("t3_tick%0d", q), 64'(quanta_tick), 64'd1);
      chk($sformatf("t3_qcnt%0d", q), 64'(quanta_count), 64'(q + 1));
      chk($sformatf("t3_start%0d", q), 64'(w_uc), (q < 2) ? 64'(BOTH_START) : 64'h0);
      cyc(1);
    end
    cyc(1);
    chk("t3_halt_uc", 64'(w_uc), 64'h0);
    chk("t3_halt_run", 64'(running), 64'd0);
    chk("t3_halt_qcnt", 64'(quanta_count), 64'd3);
    cfg_write(2'd0, 32'd5);
    cyc(1);
    cfg_idle();
    chk("t3_resume", 64'(w_uc), 64'(BOTH_START));
    cyc(1);
    unit_done = 2'b11;
    cyc(1);
    unit_done = 2'b00;
    chk("t3_q4", 64'(quanta_count), 64'd4);
    chk("t3_q4_start", 64'(w_uc), 64'(BOTH_START));
    cyc(1);
    unit_done = 2'b11;
    cyc(1);
    unit_done = 2'b00;
    chk("t3_q5", 64'(quanta_count), 64'd5);
    chk("t3_q5_nostart", 64'(w_uc), 64'h0);

    // Test 4: stop mid-quantum -> completes, no START; start -> START next cycle
    cfg_write(2'd0, 32'd0);
    cyc(1);
    cfg_idle();
    chk("t4_unlimited", 64'(w_uc), 64'(BOTH_START));
    cyc(1);
    dma2tm.tm_dbg_stop = 1'b1;
    cyc(1);
    dma2tm.tm_dbg_stop = 1'b0;
    unit_done = 2'b01;
    cyc(1);
    unit_done = 2'b00;
    chk("t4_tick_early", 64'(quanta_tick), 64'd0);
    unit_done = 2'b10;
    cyc(1);
    unit_done = 2'b00;
    chk("t4_tick", 64'(quanta_tick), 64'd1);
    chk("t4_qcnt", 64'(quanta_count), 64'd6);
    chk("t4_nostart", 64'(w_uc), 64'h0);
    cyc(2);
    chk("t4_halt_run", 64'(running), 64'd0);
    chk("t4_halt_uc", 64'(w_uc), 64'h0);
    dma2tm.tm_dbg_start = 1'b1;
    cyc(1);
    dma2tm.tm_dbg_start = 1'b0;
    chk("t4_restart", 64'(w_uc), 64'(BOTH_START));

    // Test 5: duplicate done[0] -> proto_err, barrier still closes; clear via word 1
    cyc(1);
    unit_done = 2'b01;
    cyc(1);
    unit_done = 2'b00;
    chk("t5_perr0", 64'(proto_err), 64'd0);
    unit_done = 2'b01;
    cyc(1);
    unit_done = 2'b00;
    chk("t5_perr1", 64'(proto_err), 64'd1);
    chk("t5_no_close", 64'(quanta_tick), 64'd0);
    unit_done = 2'b10;
    cyc(1);
    unit_done = 2'b00;
    chk("t5_tick", 64'(quanta_tick), 64'd1);
    chk("t5_qcnt", 64'(quanta_count), 64'd7);
    chk("t5_last", 64'(last_host_cyc), 64'd3);
    cfg_write(2'd1, 32'd1);
    cyc(1);
    cfg_idle();
    chk("t5_perr_clr", 64'(proto_err), 64'd0);
    chk("t5_last_clr", 64'(last_host_cyc), 64'd0);

    // Test 6: reset mid-quantum with done_mask=01
    unit_done = 2'b01;
    cyc(1);
    unit_done = 2'b00;
    rst = 1'b1;
    cyc(1);
    chk_reset("t6");
    rst = 1'b0;
    unit_done = 2'b10;
    cyc(1);
    unit_done = 2'b00;
    chk("t6_mask_clear", 64'(quanta_tick), 64'd0);
    unit_done = 2'b01;
    cyc(1);
    unit_done = 2'b00;
    chk("t6_tick", 64'(quanta_tick), 64'd1);
    chk("t6_qcnt", 64'(quanta_count), 64'd1);
    chk("t6_last", 64'(last_host_cyc), 64'd2);
    chk("t6_nostart", 64'(w_uc), 64'h0);
    cyc(1);
    unit_done = 2'b01;
    cyc(1);
    unit_done = 2'b00;
    chk("t6_perr_halt", 64'(proto_err), 64'd1);
    chk("t6_qcnt_hold", 64'(quanta_count), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
